// File: rtl/rr_grant_scheduler_8_if.sv
// Request/grant bundle between eight requesters and the round-robin scheduler.
// The master side drives the level requests; the slave side returns the grant.
interface rr_grant_scheduler_8_if;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_en;
  logic       preempt;

  modport master (
    output req,
    input  gnt,
    input  gnt_idx,
    input  gnt_en,
    input  preempt
  );

  modport slave (
    input  req,
    output gnt,
    output gnt_idx,
    output gnt_en,
    output preempt
  );
endinterface

// File: rtl/rr_grant_scheduler_8.sv
// 8-way round-robin arbiter with grant hold, max-hold preemption and a
// one-cycle turnaround gap between owners. All outputs are registered.
module rr_grant_scheduler_8 #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rr_grant_scheduler_8_if.slave bus
);

  localparam logic [CNT_W-1:0] MAX_HOLD_C = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [2:0]       ptr_reg, ptr_next;
  logic [CNT_W-1:0] hold_cnt_reg, hold_cnt_next;
  logic [7:0]       gnt_reg, gnt_next;
  logic [2:0]       gnt_idx_reg, gnt_idx_next;
  logic             gnt_en_reg, gnt_en_next;
  logic             preempt_reg, preempt_next;

  // Requests rotated so that bit 0 corresponds to the requester at ptr.
  logic [7:0] rot_req;
  logic [2:0] win_off;
  logic [2:0] win_idx;
  logic       any_req;
  logic       owner_req;
  logic       others_waiting;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_rot
      assign rot_req[gi] = bus.req[3'(ptr_reg + 3'(gi))];
    end
  endgenerate

  always_comb begin
    win_off = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (rot_req[k]) begin
        win_off = 3'(k);
      end
    end
  end

  assign win_idx        = 3'(ptr_reg + win_off);
  assign any_req        = |bus.req;
  assign owner_req      = bus.req[gnt_idx_reg];
  assign others_waiting = |(bus.req & ~gnt_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      ptr_reg      <= 3'd0;
      hold_cnt_reg <= '0;
      gnt_reg      <= 8'd0;
      gnt_idx_reg  <= 3'd0;
      gnt_en_reg   <= 1'b0;
      preempt_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      hold_cnt_reg <= hold_cnt_next;
      gnt_reg      <= gnt_next;
      gnt_idx_reg  <= gnt_idx_next;
      gnt_en_reg   <= gnt_en_next;
      preempt_reg  <= preempt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    hold_cnt_next = hold_cnt_reg;
    gnt_next      = gnt_reg;
    gnt_idx_next  = gnt_idx_reg;
    gnt_en_next   = gnt_en_reg;
    preempt_next  = 1'b0;

    case (state_reg)
      ST_IDLE, ST_GAP: begin
        if (any_req) begin
          state_next    = ST_GRANT;
          gnt_next      = 8'b1 << win_idx;
          gnt_idx_next  = win_idx;
          gnt_en_next   = 1'b1;
          hold_cnt_next = ONE_C;
        end else begin
          state_next    = ST_IDLE;
          gnt_next      = 8'd0;
          gnt_idx_next  = 3'd0;
          gnt_en_next   = 1'b0;
          hold_cnt_next = '0;
        end
      end

      ST_GRANT: begin
        // Release takes priority over preemption, so preempt stays low then.
        if (!owner_req || (hold_cnt_reg >= MAX_HOLD_C && others_waiting)) begin
          state_next    = ST_GAP;
          ptr_next      = 3'(gnt_idx_reg + 3'd1);
          gnt_next      = 8'd0;
          gnt_idx_next  = 3'd0;
          gnt_en_next   = 1'b0;
          hold_cnt_next = '0;
          preempt_next  = owner_req;
        end else if (hold_cnt_reg < MAX_HOLD_C) begin
          hold_cnt_next = hold_cnt_reg + ONE_C;
        end else begin
          hold_cnt_next = MAX_HOLD_C;
        end
      end

      default: begin
        state_next    = ST_IDLE;
        gnt_next      = 8'd0;
        gnt_idx_next  = 3'd0;
        gnt_en_next   = 1'b0;
        hold_cnt_next = '0;
      end
    endcase
  end

  assign bus.gnt     = gnt_reg;
  assign bus.gnt_idx = gnt_idx_reg;
  assign bus.gnt_en  = gnt_en_reg;
  assign bus.preempt = preempt_reg;

endmodule

// File: doc/rr_grant_scheduler_8.md
Name: rr_grant_scheduler_8

Overview:
8-way round-robin arbiter that shares one decoded resource (e.g. an 8-line select bus) between eight requesters. It accepts level requests and issues a one-hot grant plus a 3-bit index and enable. The index/enable pair drives a downstream 3-to-8 decode path directly. Grants are held while requested, can be preempted after a maximum hold time, and are separated by a one-cycle turnaround gap.

Parameters:
MAX_HOLD, 8, cycles an owner may hold the grant before forced preemption when others are waiting; legal range 1..2^CNT_W-1
CNT_W, 4, width of the hold counter

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
req  input  8  level request per requester; bit i = requester i
gnt  output  8  registered one-hot grant; all-zero when no owner
gnt_idx  output  3  registered binary index of owner; 0 when no owner
gnt_en  output  1  registered; 1 iff gnt != 0; gnt == decode(gnt_idx) gated by gnt_en
preempt  output  1  registered one-cycle pulse on forced preemption

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, gnt=0, gnt_idx=0, gnt_en=0, preempt=0, ptr=0, hold_cnt=0. Outputs go to these values immediately, without waiting for clk. Reset mid-grant drops the grant with no gap cycle. Operation resumes on the first edge after rst_n rises.
- All outputs registered. Request-to-grant latency is 1 edge from IDLE and 2 edges from GRANT, counting the GAP.
- Winner selection: first set bit of req, searching ptr, ptr+1, ... ptr+7, wrapping mod 8.
- States:
  - IDLE:
    - req==0: stay in IDLE.
    - else: go to GRANT. Owner = winner, gnt/gnt_idx/gnt_en set, hold_cnt=1.
  - GRANT, evaluated each edge in priority order:
    1. req[owner]==0 (release): go to GAP. Outputs cleared, ptr=owner+1 mod 8, preempt=0.
    2. hold_cnt>=MAX_HOLD and (req & ~gnt)!=0: go to GAP. Outputs cleared, ptr=owner+1 mod 8, preempt=1 for exactly one cycle.
    3. Otherwise: stay in GRANT. hold_cnt saturating increment, clamped at MAX_HOLD. With no competing request the owner keeps the grant indefinitely and no preempt is issued.
  - GAP: exactly one cycle with gnt=0, preempt cleared at the next edge. Arbitration at that edge uses the same rule as IDLE. A grant to the same requester is allowed if it is the only one requesting.
- Simultaneous release and max-hold: release wins, preempt stays 0.
- A requester that drops req during GAP or IDLE is simply not considered.
- ptr wraps 7->0. ptr changes only on the GRANT->GAP transition.
- gnt never has more than one bit set. gnt_en==|gnt at all times.
- No combinational path from req to any output.

Test Plan:
1. Async reset: drive rst_n=0 mid-cycle while gnt=0x10 -> gnt=0x00, gnt_idx=0, gnt_en=0, preempt=0 before the next clk edge. After release, req=0x10 -> gnt=0x10 one edge later (ptr back to 0 does not block 4).
2. Single request/release: req=0x01 from reset -> gnt=0x01, idx=0, en=1 after 1 edge. Drop req[0] after 3 grant cycles -> gnt=0 next edge, then IDLE with outputs held at 0.
3. Full contention, MAX_HOLD=8, req=0xFF held -> owners 0,1,2,...,7,0 in sequence. Each owner holds 8 cycles, then a 1-cycle gap; preempt pulses once per handoff; period 9 cycles.
4. Round-robin wrap on release: req=0x81 -> owner 0. Drop req[0] -> gap -> owner 7. Drop req[7] and set req=0x81 again -> gap -> owner 0 (ptr wrapped to 0).
5. No competitor: req=0x04 held 20 cycles -> gnt=0x04 continuous, preempt never asserted, hold_cnt saturates at 8. Assert req[1] -> next edge gap with preempt=1, following edge gnt=0x02.
6. Release coinciding with max-hold: req=0x03 and owner 0 at hold_cnt=8. Drop req[0] on that edge -> gap with preempt=0, then gnt=0x02.
